phy_rx_idelay_ctrl: RTL and testbench

Runtime-adjustable input-delay block for the RGMII Rx PHY datapath. It instantiates one IDELAYE2 per channel in VAR_LOAD mode and owns a small sequencer that brings every tap to a default after IDELAYCTRL is ready. It then serves load, increment, decrement and read requests from the control plane over a valid/ready handshake. It sits between the Rx pads and the RGMII DDR capture logic and replaces the fixed-delay block, so eye centring can be tuned without a rebuild.

---
 rtl/phy_rx_idelay_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_phy_rx_idelay_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_idelay_ctrl.sv
// phy_rx_idelay_ctrl: runtime-adjustable IDELAYE2 bank for the RGMII Rx path.
// A sequencer loads every tap to DEFAULT_TAP once IDELAYCTRL is ready. It then
// serves LOAD/INC/DEC/READ requests. Per-channel shadow taps mirror the
// primitive counts and are the source of every response.

// Per-channel delay element. Synthesis maps to IDELAYE2 in VAR_LOAD mode.
// Elsewhere a behavioural counter stands in for the primitive's tap register.
module phy_rx_idelay_lane #(
  parameter int  TAP_W            = 5,
  parameter real REFCLK_FREQUENCY = 199.5
) (
  input  logic             clk,
  input  logic             ld,
  input  logic             ce,
  input  logic             inc,
  input  logic [TAP_W-1:0] cntvaluein,
  input  logic             idatain,
  output logic             dataout,
  output logic [TAP_W-1:0] cntvalueout
);
  if (!((REFCLK_FREQUENCY >= 190.0 && REFCLK_FREQUENCY <= 210.0) ||
        (REFCLK_FREQUENCY >= 290.0 && REFCLK_FREQUENCY <= 310.0))) begin : g_bad_refclk
    $error("REFCLK_FREQUENCY outside the IDELAYE2 calibrated ranges");
  end

`ifdef SYNTHESIS
  IDELAYE2 #(
    .CINVCTRL_SEL          ("FALSE"),
    .DELAY_SRC             ("IDATAIN"),
    .HIGH_PERFORMANCE_MODE ("TRUE"),
    .IDELAY_TYPE           ("VAR_LOAD"),
    .IDELAY_VALUE          (0),
    .PIPE_SEL              ("FALSE"),
    .REFCLK_FREQUENCY      (REFCLK_FREQUENCY),
    .SIGNAL_PATTERN        ("DATA")
  ) u_idelay (
    .CNTVALUEOUT (cntvalueout),
    .DATAOUT     (dataout),
    .C           (clk),
    .CE          (ce),
    .CINVCTRL    (1'b0),
    .CNTVALUEIN  (cntvaluein),
    .DATAIN      (1'b0),
    .IDATAIN     (idatain),
    .INC         (inc),
    .LD          (ld),
    .LDPIPEEN    (1'b0),
    .REGRST      (1'b0)
  );
`else
  // Tap counter model: LD loads, CE steps in the INC direction; data passes through.
  always_ff @(posedge clk) begin
    if (ld)      cntvalueout <= cntvaluein;
    else if (ce) cntvalueout <= inc ? cntvalueout + 1'b1 : cntvalueout - 1'b1;
  end
  assign dataout = idatain;
`endif
endmodule

module phy_rx_idelay_ctrl #(
  parameter int  NUM_CH           = 5,
  parameter int  TAP_W            = 5,
  parameter int  DEFAULT_TAP      = 0,
  parameter int  SETTLE_CYC       = 4,
  parameter real REFCLK_FREQUENCY = 199.5,
  localparam int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              idelayctrl_rdy,
  input  logic [NUM_CH-1:0] phy_rx_in,
  output logic [NUM_CH-1:0] phy_rx_delay,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_op,
  input  logic              cfg_bcast,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [TAP_W-1:0]  cfg_tap,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [TAP_W-1:0]  rsp_tap,
  output logic              init_done
);
  localparam int              SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [TAP_W-1:0] DEF = TAP_W'(DEFAULT_TAP);

  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("SETTLE_CYC must be at least 1");
  end

  typedef enum logic [1:0] {OP_LOAD, OP_INC, OP_DEC, OP_READ} op_e;
  typedef enum logic [2:0] {ST_WAIT_RDY, ST_INIT, ST_IDLE, ST_APPLY, ST_SETTLE, ST_RESP} state_e;

  state_e                        state;
  logic                          rdy_meta, rdy_sync, rdy_prev;
  logic [CH_W-1:0]               ch_cnt;
  logic [SW-1:0]                 settle_cnt;
  logic                          init_phase;
  op_e                           req_op;
  logic                          req_bcast;
  logic [CH_W-1:0]               req_ch;
  logic [TAP_W-1:0]              req_tap;
  logic                          err_q;
  logic [NUM_CH-1:0][TAP_W-1:0]  shadow;
  logic [NUM_CH-1:0]             ld_q, ce_q;
  logic                          inc_q;
  logic [TAP_W-1:0]              cntin_q;
  logic [NUM_CH-1:0][TAP_W-1:0]  cnt_unused;   // primitive counts, kept for debug visibility

  logic [NUM_CH-1:0]             tgt;
  logic                          ch_ok, range_err, sat_hit, is_write;
  logic [TAP_W-1:0]              sel_tap;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    phy_rx_idelay_lane #(.TAP_W(TAP_W), .REFCLK_FREQUENCY(REFCLK_FREQUENCY)) u_lane (
      .clk         (clk),
      .ld          (ld_q[i]),
      .ce          (ce_q[i]),
      .inc         (inc_q),
      .cntvaluein  (cntin_q),
      .idatain     (phy_rx_in[i]),
      .dataout     (phy_rx_delay[i]),
      .cntvalueout (cnt_unused[i])
    );
  end

  // Decode the latched request: target mask, range and saturation rejects, readback tap.
  always_comb begin
    is_write  = (req_op != OP_READ);
    ch_ok     = (int'(req_ch) < NUM_CH);
    tgt       = '0;
    if (req_bcast && is_write) tgt = '1;
    else if (ch_ok)            tgt[req_ch] = 1'b1;
    range_err = !ch_ok && !(req_bcast && is_write);
    sat_hit   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tgt[i] && req_op == OP_INC && shadow[i] == '1) sat_hit = 1'b1;
      if (tgt[i] && req_op == OP_DEC && shadow[i] == '0) sat_hit = 1'b1;
    end
    sel_tap   = ch_ok ? shadow[req_ch] : '0;
  end

  // rdy synchroniser, sequencer FSM, shadow taps and registered LD/CE/response outputs.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state      <= ST_WAIT_RDY;
      rdy_meta   <= 1'b0;
      rdy_sync   <= 1'b0;
      rdy_prev   <= 1'b0;
      ch_cnt     <= '0;
      settle_cnt <= '0;
      init_phase <= 1'b0;
      req_op     <= OP_LOAD;
      req_bcast  <= 1'b0;
      req_ch     <= '0;
      req_tap    <= '0;
      err_q      <= 1'b0;
      shadow     <= {NUM_CH{DEF}};
      ld_q       <= '0;
      ce_q       <= '0;
      inc_q      <= 1'b0;
      cntin_q    <= DEF;
      cfg_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tap    <= '0;
      init_done  <= 1'b0;
    end else begin
      rdy_meta  <= idelayctrl_rdy;
      rdy_sync  <= rdy_meta;
      rdy_prev  <= rdy_sync;
      ld_q      <= '0;
      ce_q      <= '0;
      rsp_valid <= 1'b0;
      if (state != ST_WAIT_RDY && !rdy_sync) begin
        // IDELAYCTRL lost lock: drop everything, in-flight request is silently abandoned.
        state      <= ST_WAIT_RDY;
        init_done  <= 1'b0;
        cfg_ready  <= 1'b0;
        init_phase <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_RDY: if (rdy_sync && rdy_prev) begin
            state  <= ST_INIT;
            ch_cnt <= '0;
          end
          ST_INIT: begin
            ld_q[ch_cnt]   <= 1'b1;
            cntin_q        <= DEF;
            shadow[ch_cnt] <= DEF;
            if (ch_cnt == CH_W'(NUM_CH - 1)) begin
              state      <= ST_SETTLE;
              settle_cnt <= '0;
              init_phase <= 1'b1;
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
          ST_IDLE: if (cfg_valid) begin
            req_op    <= op_e'(cfg_op);
            req_bcast <= cfg_bcast;
            req_ch    <= cfg_ch;
            req_tap   <= cfg_tap;
            cfg_ready <= 1'b0;
            state     <= ST_APPLY;
          end
          ST_APPLY: begin
            err_q      <= range_err || sat_hit;
            settle_cnt <= '0;
            if (range_err || sat_hit || req_op == OP_READ) begin
              state <= ST_RESP;
            end else begin
              state <= ST_SETTLE;
              case (req_op)
                OP_LOAD: begin
                  ld_q    <= tgt;
                  cntin_q <= req_tap;
                  for (int i = 0; i < NUM_CH; i++) if (tgt[i]) shadow[i] <= req_tap;
                end
                OP_INC: begin
                  ce_q  <= tgt;
                  inc_q <= 1'b1;
                  for (int i = 0; i < NUM_CH; i++) if (tgt[i]) shadow[i] <= shadow[i] + 1'b1;
                end
                default: begin
                  ce_q  <= tgt;
                  inc_q <= 1'b0;
                  for (int i = 0; i < NUM_CH; i++) if (tgt[i]) shadow[i] <= shadow[i] - 1'b1;
                end
              endcase
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
              if (init_phase) begin
                state      <= ST_IDLE;
                init_phase <= 1'b0;
                init_done  <= 1'b1;
                cfg_ready  <= 1'b1;
              end else begin
                state <= ST_RESP;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_RESP: begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_tap   <= sel_tap;
            cfg_ready <= 1'b1;
            state     <= ST_IDLE;
          end
          default: state <= ST_WAIT_RDY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_phy_rx_idelay_ctrl.sv
// Self-checking bench for phy_rx_idelay_ctrl: directed steps plus random requests,
// checked against a per-channel tap array model with the block's accept/reject rules.
module tb_phy_rx_idelay_ctrl;
  localparam int NUM_CH = 5;
  localparam int TAP_W  = 5;
  localparam int DEF    = 3;
  localparam int SETTLE = 4;
  localparam int TMAX   = 31;
  localparam int LOAD = 0, INC = 1, DEC = 2, READ = 3;

  logic              clk = 1'b0;
  logic              srst_n = 1'b0;
  logic              rdy = 1'b0;
  logic [NUM_CH-1:0] phy_rx_in = '0;
  logic [NUM_CH-1:0] phy_rx_delay;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_op = '0;
  logic              cfg_bcast = 1'b0;
  logic [2:0]        cfg_ch = '0;
  logic [TAP_W-1:0]  cfg_tap = '0;
  logic              rsp_valid, rsp_err, init_done;
  logic [TAP_W-1:0]  rsp_tap;

  always #5 clk = ~clk;

  phy_rx_idelay_ctrl #(
    .NUM_CH(NUM_CH), .TAP_W(TAP_W), .DEFAULT_TAP(DEF), .SETTLE_CYC(SETTLE),
    .REFCLK_FREQUENCY(199.5)
  ) dut (
    .clk(clk), .srst_n(srst_n), .idelayctrl_rdy(rdy), .phy_rx_in(phy_rx_in),
    .phy_rx_delay(phy_rx_delay), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_op(cfg_op), .cfg_bcast(cfg_bcast), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_tap(rsp_tap), .init_done(init_done)
  );

  int n_chk = 0;
  int n_fail = 0;
  int mt[NUM_CH];

  // free-running pulse/response counters; steps diff snapshots of these
  int ld_cyc = 0, ld_bits = 0, ce_cyc = 0, rsp_cnt = 0;
  always @(posedge clk) begin
    if (dut.ld_q != '0) ld_cyc = ld_cyc + 1;
    ld_bits = ld_bits + $countones(dut.ld_q);
    if (dut.ce_q != '0) ce_cyc = ce_cyc + 1;
    if (rsp_valid) rsp_cnt = rsp_cnt + 1;
  end

  typedef struct { logic err; int tap; } exp_t;
  exp_t eq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) mt[i] = DEF;
  endfunction

  // Reference: decide accept/reject from the rules, then apply to the tap array.
  function automatic void model_step(input int op, input int bc, input int ch, input int tap,
                                     output logic err, output int tap_o, output int lat);
    int  writes = (op != READ);
    int  all = bc && writes;
    err = 1'b0;
    if (!all && ch >= NUM_CH) err = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (all || i == ch) begin
        if (op == INC && mt[i] == TMAX) err = 1'b1;
        if (op == DEC && mt[i] == 0)    err = 1'b1;
      end
    if (!err && writes)
      for (int i = 0; i < NUM_CH; i++)
        if (all || i == ch) mt[i] = (op == LOAD) ? tap : (op == INC) ? mt[i] + 1 : mt[i] - 1;
    tap_o = (ch < NUM_CH) ? mt[ch] : 0;
    lat   = (err || op == READ) ? 2 : 2 + SETTLE;
  endfunction

  task automatic chk_shadows(input string tag);
    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("%s_shadow%0d", tag, i), dut.shadow[i], mt[i]);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 200) begin tick(); n++; end
    chk({tag, "_init_done"}, init_done, 1);
  endtask

  // One request: check latency, response fields, pulse activity and strobe width.
  task automatic send(input string tag, input int op, input int bc, input int ch, input int tap);
    logic e_err; int e_tap, e_lat, lat, n, l0, c0;
    n = 0;
    while (!cfg_ready && n < 100) begin tick(); n++; end
    chk({tag, "_ready"}, cfg_ready, 1);
    model_step(op, bc, ch, tap, e_err, e_tap, e_lat);
    cfg_op = 2'(op); cfg_bcast = bc[0]; cfg_ch = 3'(ch); cfg_tap = TAP_W'(tap);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    l0 = ld_cyc; c0 = ce_cyc; lat = 0;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_err"}, rsp_err, e_err);
    chk({tag, "_tap"}, rsp_tap, e_tap);
    tick();
    chk({tag, "_strobe"}, rsp_valid, 0);
    chk({tag, "_ld"}, ld_cyc - l0, (op == LOAD && !e_err) ? 1 : 0);
    chk({tag, "_ce"}, ce_cyc - c0, ((op == INC || op == DEC) && !e_err) ? 1 : 0);
  endtask

  int hop[8] = '{LOAD, INC, READ, DEC, READ, LOAD, INC, READ};
  int hbc[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
  int hch[8] = '{1, 1, 1, 0, NUM_CH, 3, 3, 3};
  int htp[8] = '{7, 0, 0, 0, 0, 31, 0, 0};

  initial begin
    int l0, b0, r0, k, got, cyc, ch, op, tap, dl;
    logic acc, e_err;
    exp_t e;

    // reset values
    repeat (4) tick();
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_tap", rsp_tap, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ld", dut.ld_q, 0);
    chk("rst_ce", dut.ce_q, 0);

    // init sequence
    srst_n = 1'b1;
    repeat (3) tick();
    chk("wait_no_ready", cfg_ready, 0);
    l0 = ld_cyc; b0 = ld_bits; r0 = rsp_cnt;
    rdy = 1'b1;
    wait_init("init");
    chk("init_ready", cfg_ready, 1);
    chk("init_ld_cycles", ld_cyc - l0, NUM_CH);
    chk("init_ld_bits", ld_bits - b0, NUM_CH);
    chk("init_no_rsp", rsp_cnt - r0, 0);
    model_reset();
    chk_shadows("init");
    chk("init_cnt0", dut.g_ch[0].u_lane.cntvalueout, DEF);
    chk("init_cnt4", dut.g_ch[4].u_lane.cntvalueout, DEF);

    // data path passes through
    phy_rx_in = NUM_CH'($urandom);
    #1 chk("datapath", phy_rx_delay, phy_rx_in);

    // load and read
    send("load2", LOAD, 0, 2, 17);
    chk("cnt2", dut.g_ch[2].u_lane.cntvalueout, 17);
    send("read2", READ, 0, 2, 0);

    // saturation
    send("load0_31", LOAD, 0, 0, 31);
    send("inc_sat", INC, 0, 0, 0);
    send("load0_0", LOAD, 0, 0, 0);
    send("dec_sat", DEC, 0, 0, 0);

    // broadcast
    send("bc_load", LOAD, 1, 0, 10);
    send("bc_inc", INC, 1, 2, 0);
    chk_shadows("bc_inc");
    send("load4_31", LOAD, 0, 4, 31);
    send("bc_inc_rej", INC, 1, 1, 0);
    chk_shadows("bc_rej");

    // back-to-back with cfg_valid held
    k = 0; got = 0; cyc = 0;
    cfg_op = 2'(hop[0]); cfg_bcast = hbc[0][0]; cfg_ch = 3'(hch[0]); cfg_tap = TAP_W'(htp[0]);
    cfg_valid = 1'b1;
    while (got < 8 && cyc < 400) begin
      acc = cfg_valid && cfg_ready;
      @(posedge clk); #1; cyc++;
      if (rsp_valid) begin
        if (eq.size() == 0) chk("hs_spurious", 1, 0);
        else begin
          e = eq.pop_front();
          chk("hs_err", rsp_err, e.err);
          chk("hs_tap", rsp_tap, e.tap);
        end
        got++;
      end
      if (acc) begin
        chk("hs_outstanding", eq.size(), 0);
        model_step(hop[k], hbc[k], hch[k], htp[k], e.err, e.tap, dl);
        eq.push_back(e);
        k++;
        if (k < 8) begin
          cfg_op = 2'(hop[k]); cfg_bcast = hbc[k][0]; cfg_ch = 3'(hch[k]); cfg_tap = TAP_W'(htp[k]);
        end else cfg_valid = 1'b0;
      end
    end
    cfg_valid = 1'b0;
    chk("hs_accepts", k, 8);
    chk("hs_responses", got, 8);

    // random traffic
    for (int n = 0; n < 50; n++) begin
      op  = int'($urandom_range(0, 3));
      ch  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NUM_CH, 7)) : int'($urandom_range(0, NUM_CH - 1));
      tap = ($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 3) == 0) ? TMAX : int'($urandom_range(0, TMAX));
      send($sformatf("rnd%0d", n), op, ($urandom_range(0, 3) == 0) ? 1 : 0, ch, tap);
    end
    chk_shadows("rnd");

    // rdy lost during SETTLE of a LOAD
    while (!cfg_ready) tick();
    r0 = rsp_cnt;
    cfg_op = 2'(LOAD); cfg_bcast = 1'b0; cfg_ch = 3'd1; cfg_tap = TAP_W'(22);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    tick();
    rdy = 1'b0;
    repeat (15) tick();
    chk("drop_no_rsp", rsp_cnt - r0, 0);
    chk("drop_init_done", init_done, 0);
    chk("drop_ready", cfg_ready, 0);
    rdy = 1'b1;
    wait_init("reinit");
    chk("reinit_no_rsp", rsp_cnt - r0, 0);
    model_reset();
    chk_shadows("reinit");
    send("reinit_read1", READ, 0, 1, 0);

    // reset asserted while in APPLY
    send("pre_rst_load", LOAD, 0, 1, 9);
    cfg_op = 2'(LOAD); cfg_bcast = 1'b0; cfg_ch = 3'd3; cfg_tap = TAP_W'(20);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    srst_n = 1'b0;
    l0 = ld_cyc;
    tick();
    chk("mid_rst_ready", cfg_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_tap", rsp_tap, 0);
    chk("mid_rst_init_done", init_done, 0);
    model_reset();
    chk_shadows("mid_rst");
    tick();
    chk("mid_rst_no_ld", ld_cyc - l0, 0);
    repeat (2) tick();
    srst_n = 1'b1;
    wait_init("post_rst");
    send("post_rst_read3", READ, 0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
